// File: rtl/axi_master_bridge_if.sv
// ----------------------------------------------------------------------------
// axi_master_bridge_if
// AXI4 single-beat subset used by axi_master_bridge: AW, W, B, AR and R
// channels.
//   master modport : drives AW/W/AR and b_ready/r_ready (the bridge side)
//   slave modport  : drives the ready inputs and the B/R channels (memory side)
// ----------------------------------------------------------------------------
interface axi_master_bridge_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  // AW channel
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_valid;
  logic                aw_ready;
  // W channel
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_valid;
  logic                w_ready;
  // B channel
  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  // AR channel
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready;
  // R channel
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_master_bridge.sv
// ----------------------------------------------------------------------------
// axi_master_bridge
// Single-outstanding AXI4 master: converts one CPU-side request into one
// single-beat AXI read or write and returns a one-cycle completion pulse.
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   req_*          request side (valid/ready, we, addr, size, wdata, wstrb)
//   resp_*         completion pulse with read data and error flag
//   axi            AXI master port (AW, W, B, AR, R channels)
// ----------------------------------------------------------------------------
module axi_master_bridge #(
  parameter int              ADDR_W = 64,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] MST_ID = {ID_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  axi_master_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          size_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic                we_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;

  logic                req_ready_s;
  logic                resp_valid_s;
  logic                aw_valid_s;
  logic                w_valid_s;
  logic                b_ready_s;
  logic                ar_valid_s;
  logic                r_ready_s;

  logic                accept_s;
  logic                aw_hs_s;
  logic                w_hs_s;
  logic                b_hs_s;
  logic                r_hs_s;

  // Completion is an error on a non-OKAY response, a foreign ID, or a missing last beat.
  function automatic logic resp_is_err(input logic [1:0]      resp,
                                       input logic [ID_W-1:0] id,
                                       input logic            last);
    return (resp != 2'b00) | (id != MST_ID) | ~last;
  endfunction

  assign accept_s = req_valid & req_ready_s;
  assign aw_hs_s  = aw_valid_s & axi.aw_ready;
  assign w_hs_s   = w_valid_s & axi.w_ready;
  assign b_hs_s   = b_ready_s & axi.b_valid;
  assign r_hs_s   = r_ready_s & axi.r_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode; valids come from registered state only,
  // the ready inputs steer the next state but never the valids.
  always_comb begin
    state_s      = state_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    aw_valid_s   = 1'b0;
    w_valid_s    = 1'b0;
    b_ready_s    = 1'b0;
    ar_valid_s   = 1'b0;
    r_ready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        if (req_valid) begin
          state_s = req_we ? WR_REQ : RD_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      WR_REQ: begin
        aw_valid_s = ~aw_done_r;
        w_valid_s  = ~w_done_r;
        // Each channel is complete if it finished earlier or completes now.
        if ((aw_done_r | axi.aw_ready) & (w_done_r | axi.w_ready)) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        b_ready_s = 1'b1;
        if (axi.b_valid) begin
          state_s = DONE;
        end else begin
          state_s = WR_RESP;
        end
      end
      RD_REQ: begin
        ar_valid_s = 1'b1;
        if (axi.ar_ready) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_REQ;
        end
      end
      RD_DATA: begin
        r_ready_s = 1'b1;
        if (axi.r_valid) begin
          state_s = DONE;
        end else begin
          state_s = RD_DATA;
        end
      end
      DONE: begin
        resp_valid_s = 1'b1;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, per-channel write done flags, and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r    <= {ADDR_W{1'b0}};
      size_r    <= 3'd0;
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {(DATA_W/8){1'b0}};
      we_r      <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r    <= req_addr;
        size_r    <= req_size;
        wdata_r   <= req_wdata;
        wstrb_r   <= req_wstrb;
        we_r      <= req_we;
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        if (aw_hs_s) begin
          aw_done_r <= 1'b1;
        end
        if (w_hs_s) begin
          w_done_r <= 1'b1;
        end
      end
      // rdata_r only moves on reads, so a write completion shows the last read data.
      if (r_hs_s) begin
        rdata_r <= axi.r_data;
      end
      if (b_hs_s | r_hs_s) begin
        err_r <= we_r ? resp_is_err(axi.b_resp, axi.b_id, 1'b1)
                      : resp_is_err(axi.r_resp, axi.r_id, axi.r_last);
      end
    end
  end

  assign req_ready    = req_ready_s;
  assign resp_valid   = resp_valid_s;
  assign resp_rdata   = rdata_r;
  assign resp_err     = err_r;

  assign axi.aw_id    = MST_ID;
  assign axi.aw_addr  = addr_r;
  assign axi.aw_len   = 8'd0;
  assign axi.aw_size  = size_r;
  assign axi.aw_burst = 2'b01;
  assign axi.aw_valid = aw_valid_s;
  assign axi.w_data   = wdata_r;
  assign axi.w_strb   = wstrb_r;
  assign axi.w_last   = 1'b1;
  assign axi.w_valid  = w_valid_s;
  assign axi.b_ready  = b_ready_s;
  assign axi.ar_id    = MST_ID;
  assign axi.ar_addr  = addr_r;
  assign axi.ar_len   = 8'd0;
  assign axi.ar_size  = size_r;
  assign axi.ar_burst = 2'b01;
  assign axi.ar_valid = ar_valid_s;
  assign axi.r_ready  = r_ready_s;

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Single-outstanding AXI4 master that turns one simple CPU-side memory request (IFU or LSU port) into one AXI single-beat read or write transaction.
- It sits between a pipeline stage and the AXI interconnect/memory slave.
- Each instance drives a fixed transaction ID.
- It returns read data and an error flag to the requester as a one-cycle response pulse.

Parameters:
- ADDR_W, 64, address width of the request port and AXI AR/AW.
- DATA_W, 64, data width of the request port and AXI R/W.
- ID_W, 4, AXI ID width.
- MST_ID, 0, constant ID driven on aw_id/ar_id and expected on b_id/r_id.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_size  in  3  AXI size code, passed unchanged to ar_size/aw_size.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  write byte strobes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data; valid with resp_valid on reads.
- resp_err  out  1  completion error; valid with resp_valid.
- axi_aw_id/addr/len/size/burst/valid  out  ID_W/ADDR_W/8/3/2/1  AW channel.
- axi_aw_ready  in  1  AW channel ready.
- axi_w_data/strb/last/valid  out  DATA_W/DATA_W/8/1/1  W channel.
- axi_w_ready  in  1  W channel ready.
- axi_b_id/resp/valid  in  ID_W/2/1  B channel.
- axi_b_ready  out  1  B channel ready.
- axi_ar_id/addr/len/size/burst/valid  out  ID_W/ADDR_W/8/3/2/1  AR channel.
- axi_ar_ready  in  1  AR channel ready.
- axi_r_id/data/resp/last/valid  in  ID_W/DATA_W/2/1/1  R channel.
- axi_r_ready  out  1  R channel ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All AXI valid/ready outputs, resp_valid and resp_err are 0; resp_rdata is 0.
  - Latched request registers are cleared.
  - A reset in the middle of a transaction abandons it; the bridge does not replay it after reset.
- Constant fields: aw/ar_len=0, aw/ar_burst=2'b01 (INCR), w_last=1 whenever w_valid=1, aw_id=ar_id=MST_ID.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - req_ready=1, combinational on state only.
  - On req_valid&req_ready, latch addr/size/wdata/wstrb/we.
  - Go to WR_REQ if we=1, else RD_REQ.
- WR_REQ:
  - aw_valid and w_valid rise together one cycle after acceptance.
  - Each valid is held, with stable payload, until its own handshake; they are tracked by two done flags.
  - aw_valid and w_valid never depend combinationally on the ready inputs.
  - Once both handshakes have occurred (same cycle or different cycles), go to WR_RESP.
- WR_RESP:
  - b_ready=1.
  - On the b handshake, err = (b_resp!=2'b00) | (b_id!=MST_ID); go to DONE.
- RD_REQ: ar_valid=1, held until ar_ready; then go to RD_DATA.
- RD_DATA:
  - r_ready=1.
  - On the r handshake, latch r_data.
  - err = (r_resp!=2'b00) | (r_id!=MST_ID) | ~r_last.
  - Go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, with resp_rdata (reads) and resp_err; then go to IDLE.
  - On writes, resp_rdata holds its previous value.
  - The requester cannot stall the response; it must sample it in that cycle.
- Outstanding transactions: at most one; req_ready=0 in every state except IDLE.
- Minimum latency against a zero-wait slave:
  - read: accept at cycle 0, ar handshake at 1, r handshake at 2, resp_valid at 3;
  - write: accept at 0, aw+w at 1, b at 2, resp_valid at 3.
- Back-to-back: a new request can be accepted in the cycle after resp_valid (IDLE).
- Ignored inputs: b_valid and r_valid are ignored outside WR_RESP and RD_DATA, and never cause a state change there.

Test Plan:
- Read, zero-wait slave returning 64'hDEAD_BEEF_0123_4567 with r_resp=00, r_id=MST_ID, r_last=1 → ar_addr=req_addr, ar_len=0, ar_burst=01; resp_valid at cycle 3 with that data and resp_err=0.
- Write addr 0x8000_0010, wdata 0x1122334455667788, wstrb 0x0F; aw_ready delayed 3 cycles, w_ready immediate → w_valid drops after 1 cycle, aw_valid held with stable payload for 3 cycles; b accepted; one resp_valid pulse with resp_err=0.
- Stall: ar_ready low for 5 cycles, r_valid delayed 4 cycles → ar_valid held for 5 cycles with constant addr; req_ready=0 throughout; exactly one resp_valid.
- Errors: r_resp=2'b10, then r_id mismatch, then r_last=0, then b_resp=2'b11 → resp_err=1 in each case, and the FSM returns to IDLE.
- Reset (rst=0) asserted while in WR_REQ with aw_valid=1 → all valids and resp_valid go to 0 immediately (asynchronously), req_ready=1 after release; a stray b_valid afterwards is ignored.
- Back-to-back read then write with req_valid held high → second request accepted in the cycle after the first resp_valid; the two responses appear in order.
